// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    localparam logic [31:0] IMEM_BASE_ADDR = 32'h0000_3000;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } imem_state_e;

    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef logic [1:0] fault_t;

endpackage

// File: rtl/imem_responder_if.sv
// Load, fetch and response signals between the PC stage and the instruction memory.
interface imem_responder_if;
    import imem_pkg::*;

    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    fault_t      rsp_fault;
    logic        mode;
    logic [31:0] fetch_cnt;

    modport master (
        output load_valid, load_data, load_last, req_valid, req_addr,
        input  load_ready, req_ready, rsp_valid, rsp_instr, rsp_fault, mode, fetch_cnt
    );

    modport slave (
        input  load_valid, load_data, load_last, req_valid, req_addr,
        output load_ready, req_ready, rsp_valid, rsp_instr, rsp_fault, mode, fetch_cnt
    );

endinterface

// File: rtl/imem_resp_pipe.sv
// STAGES-deep delay line for {valid, fault, instr}; every stage clears on reset.
module imem_resp_pipe
    import imem_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid_i,
    input  fault_t      in_fault_i,
    input  logic [31:0] in_instr_i,
    output logic        out_valid_o,
    output fault_t      out_fault_o,
    output logic [31:0] out_instr_o
);

    logic        valid_c [STAGES+1];
    fault_t      fault_c [STAGES+1];
    logic [31:0] instr_c [STAGES+1];

    assign valid_c[0] = in_valid_i;
    assign fault_c[0] = in_fault_i;
    assign instr_c[0] = in_instr_i;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic        valid_q;
            fault_t      fault_q;
            logic [31:0] instr_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    fault_q <= '0;
                    instr_q <= '0;
                end else begin
                    valid_q <= valid_c[gi];
                    fault_q <= fault_c[gi];
                    instr_q <= instr_c[gi];
                end
            end

            assign valid_c[gi+1] = valid_q;
            assign fault_c[gi+1] = fault_q;
            assign instr_c[gi+1] = instr_q;
        end
    endgenerate

    assign out_valid_o = valid_c[STAGES];
    assign out_fault_o = fault_c[STAGES];
    assign out_instr_o = instr_c[STAGES];

endmodule

// File: rtl/imem_responder.sv
// Instruction memory: boot-time word-stream fill, then fixed-latency pipelined fetches.
// Define IMEM_FETCH_CNT_EN to build the accepted-fetch counter on fetch_cnt.
module imem_responder
    import imem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = IMEM_BASE_ADDR,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 1
) (
    input  logic                clk,
    input  logic                reset,
    imem_responder_if.slave     bus
);

    localparam int          DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [31:0] RANGE_BYTES = 32'(64'(4) << DEPTH_LOG2);

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("imem_responder: LATENCY must be within 1..4");
        end
        if (DEPTH_LOG2 > 28) begin : g_bad_depth
            $error("imem_responder: DEPTH_LOG2 must not exceed 28");
        end
    endgenerate

    imem_state_e           state_q;
    logic [DEPTH_LOG2-1:0] ptr_q;
    logic [DEPTH_LOG2-1:0] ptr_d;
    logic                  mode_q;
    logic                  load_ready_q;
    logic                  req_ready_q;

    logic load_fire;
    logic req_fire;
    assign load_fire = bus.load_valid && load_ready_q;
    assign req_fire  = bus.req_valid && req_ready_q;
    assign ptr_d     = ptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            ptr_q        <= '0;
            mode_q       <= 1'b0;
            load_ready_q <= 1'b1;
            req_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (load_fire) begin
                        ptr_q <= ptr_d;
                        if (bus.load_last || ptr_q == '1) begin
                            state_q      <= ST_RUN;
                            mode_q       <= 1'b1;
                            load_ready_q <= 1'b0;
                            req_ready_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: ;
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    // Offset wraps below BASE_ADDR, so one unsigned compare covers both range ends.
    logic [31:0]           offset_d;
    fault_t                fault_d;
    logic [DEPTH_LOG2-1:0] index_d;

    always_comb begin
        offset_d                = bus.req_addr - BASE_ADDR;
        fault_d                 = '0;
        fault_d[FAULT_MISALIGN] = |offset_d[1:0];
        fault_d[FAULT_RANGE]    = offset_d >= RANGE_BYTES;
        index_d                 = offset_d[DEPTH_LOG2+1:2];
    end

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem_q[ptr_q] <= bus.load_data;
        end
        if (req_fire) begin
            rd_data_q <= mem_q[index_d];
        end
    end

    logic   s1_valid_q;
    fault_t s1_fault_q;
    logic [31:0] s1_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_fault_q <= '0;
        end else begin
            s1_valid_q <= req_fire;
            s1_fault_q <= req_fire ? fault_d : fault_t'('0);
        end
    end

    // The read register has no reset, so mask it until a clean response is present.
    assign s1_instr = (s1_valid_q && s1_fault_q == '0) ? rd_data_q : NOP_INSTR;

    generate
        if (LATENCY > 1) begin : g_pipe
            imem_resp_pipe #(
                .STAGES(LATENCY - 1)
            ) u_pipe (
                .clk        (clk),
                .reset      (reset),
                .in_valid_i (s1_valid_q),
                .in_fault_i (s1_fault_q),
                .in_instr_i (s1_instr),
                .out_valid_o(bus.rsp_valid),
                .out_fault_o(bus.rsp_fault),
                .out_instr_o(bus.rsp_instr)
            );
        end else begin : g_direct
            assign bus.rsp_valid = s1_valid_q;
            assign bus.rsp_fault = s1_fault_q;
            assign bus.rsp_instr = s1_instr;
        end
    endgenerate

    assign bus.load_ready = load_ready_q;
    assign bus.req_ready  = req_ready_q;
    assign bus.mode       = mode_q;

`ifdef IMEM_FETCH_CNT_EN
    logic [31:0] fetch_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
        end else if (req_fire) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign bus.fetch_cnt = fetch_cnt_q;
`else
    assign bus.fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder at LATENCY=3 with an in-order response scoreboard.
module tb_imem_responder;
    import imem_pkg::*;

    localparam int LAT = 3;
`ifdef IMEM_FETCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  fault;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    imem_responder_if bus_if ();

    imem_responder #(
        .LATENCY(LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && bus_if.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rsp", 32'(bus_if.rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_instr", bus_if.rsp_instr, e.instr);
                chk("rsp_fault", 32'(bus_if.rsp_fault), 32'(e.fault));
                chk("rsp_latency", 32'(cyc - e.cyc), 32'(LAT));
                $display("rsp  instr=%h fault=%b cycle=%0d", bus_if.rsp_instr, bus_if.rsp_fault, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        bus_if.load_valid = 1'b1;
        bus_if.load_data  = d;
        bus_if.load_last  = last;
        step();
        bus_if.load_valid = 1'b0;
        bus_if.load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic [1:0] ef);
        exp_t e;
        e.instr = ei;
        e.fault = ef;
        e.cyc   = cyc;
        exp_q.push_back(e);
        $display("req  addr=%h expect instr=%h fault=%b", a, ei, ef);
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = a;
        step();
        bus_if.req_valid = 1'b0;
        exp_cnt++;
    endtask

    task automatic drain();
        for (int i = 0; i < LAT + 4 && exp_q.size() != 0; i++) step();
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic chk_cnt(input string tag);
        chk(tag, bus_if.fetch_cnt, CNT_EN ? 32'(exp_cnt) : 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d expected < 100000", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset             = 1'b1;
        bus_if.load_valid = 1'b0;
        bus_if.load_data  = '0;
        bus_if.load_last  = 1'b0;
        bus_if.req_valid  = 1'b0;
        bus_if.req_addr   = '0;
        repeat (3) step();

        chk("rst_mode", 32'(bus_if.mode), 32'd0);
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("rst_rsp_instr", bus_if.rsp_instr, 32'd0);
        chk("rst_rsp_fault", 32'(bus_if.rsp_fault), 32'd0);
        chk("rst_load_ready", 32'(bus_if.load_ready), 32'd1);
        chk("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
        chk_cnt("rst_fetch_cnt");
        reset = 1'b0;
        step();

        // Requests during LOAD must be refused.
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = 32'h0000_3000;
        for (int i = 0; i < 4; i++) begin
            chk("load_req_ready", 32'(bus_if.req_ready), 32'd0);
            step();
        end
        bus_if.req_valid = 1'b0;
        repeat (LAT + 1) step();
        chk_cnt("load_fetch_cnt");

        load_word(32'h1111_1111, 1'b0);
        load_word(32'h2222_2222, 1'b0);
        chk("mode_before_last", 32'(bus_if.mode), 32'd0);
        load_word(32'h3333_3333, 1'b1);
        chk("mode_after_last", 32'(bus_if.mode), 32'd1);
        chk("load_ready_run", 32'(bus_if.load_ready), 32'd0);
        chk("req_ready_run", 32'(bus_if.req_ready), 32'd1);

        fetch(32'h0000_3004, 32'h2222_2222, 2'b00);
        drain();

        fetch(32'h0000_3000, 32'h1111_1111, 2'b00);
        fetch(32'h0000_3008, 32'h3333_3333, 2'b00);
        fetch(32'h0000_3004, 32'h2222_2222, 2'b00);
        fetch(32'h0000_3002, NOP_INSTR, 2'b01);
        drain();
        chk_cnt("fetch_cnt_5");

        fetch(32'h0000_2FFC, NOP_INSTR, 2'b10);
        fetch(32'h0000_7000, NOP_INSTR, 2'b10);
        fetch(32'h0000_2FFE, NOP_INSTR, 2'b11);
        drain();
        chk_cnt("fetch_cnt_8");

        // Reset with two fetches in flight drops both responses.
        fetch(32'h0000_3000, 32'h1111_1111, 2'b00);
        fetch(32'h0000_3004, 32'h2222_2222, 2'b00);
        do_reset();
        chk("flush_mode", 32'(bus_if.mode), 32'd0);
        chk("flush_load_ready", 32'(bus_if.load_ready), 32'd1);
        chk("flush_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk_cnt("flush_fetch_cnt");
        repeat (LAT + 2) step();

        load_word(32'hDEAD_BEEF, 1'b1);
        chk("reload_mode", 32'(bus_if.mode), 32'd1);
        fetch(32'h0000_3000, 32'hDEAD_BEEF, 2'b00);
        fetch(32'h0000_3008, 32'h3333_3333, 2'b00);
        drain();
        chk_cnt("reload_fetch_cnt");

        // Full fill without load_last.
        do_reset();
        for (int i = 0; i < 4096; i++) begin
            load_word(32'hA000_0000 + 32'(i), 1'b0);
            if (i == 4094) chk("fill_mode_4095", 32'(bus_if.mode), 32'd0);
        end
        chk("fill_mode_done", 32'(bus_if.mode), 32'd1);
        bus_if.load_valid = 1'b1;
        bus_if.load_data  = 32'hFFFF_FFFF;
        chk("fill_extra_ready", 32'(bus_if.load_ready), 32'd0);
        step();
        bus_if.load_valid = 1'b0;

        fetch(32'h0000_3000, 32'hA000_0000, 2'b00);
        fetch(32'h0000_6FFC, 32'hA000_0FFF, 2'b00);
        fetch(32'h0000_3004, 32'hA000_0001, 2'b00);
        fetch(32'h0000_7000, NOP_INSTR, 2'b10);
        drain();
        chk_cnt("fill_fetch_cnt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder at the far end of the fetch path: accepts byte-address fetch requests from the PC stage and returns 32-bit instruction words with fixed latency.
- Holds program storage loaded through a word-stream load port after reset.
- Two modes: LOAD (boot-time program fill) and RUN (serve fetches).
- Flags misaligned and out-of-range fetches and returns a NOP for them.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address of instruction word 0.
- DEPTH_LOG2, 12, log2 of storage depth in words (4096 words).
- LATENCY, 1, cycles from request accept to response; legal range 1..4.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- load_valid  in  1  load word present.
- load_data  in  32  program word.
- load_last  in  1  final word of the program.
- load_ready  out  1  responder accepts a load word.
- req_valid  in  1  fetch request present.
- req_addr  in  32  fetch byte address.
- req_ready  out  1  responder accepts a fetch.
- rsp_valid  out  1  response present; no backpressure.
- rsp_instr  out  32  instruction word, or 0 on fault.
- rsp_fault  out  2  bit0 misaligned, bit1 out of range.
- mode  out  1  0 = LOAD, 1 = RUN.
- fetch_cnt  out  32  count of accepted fetches (optional feature).

Behaviour:
- Clocking and reset: clk only; reset is synchronous, active-high.
- Reset values: state LOAD, load pointer 0, all pipeline valids 0, mode=0, rsp_valid=0, rsp_instr=0, rsp_fault=0, fetch_cnt=0. Storage contents are not cleared.
- LOAD state:
  - load_ready=1, req_ready=0.
  - On load_valid&&load_ready: store load_data at the pointer, then increment the pointer.
  - Handshaked load_last, or a handshake when pointer==2^DEPTH_LOG2-1, moves to RUN next cycle. Remaining words keep their old contents.
  - req_valid is ignored; no request is accepted.
- RUN state:
  - load_ready=0, req_ready=1; load_valid is ignored.
  - Stays in RUN until reset.
- Fetch accept is req_valid&&req_ready. On accept:
  - offset = req_addr - BASE_ADDR, 32-bit modular (wraps below base).
  - misaligned = offset[1:0]!=0.
  - out_of_range = offset >= 4*2^DEPTH_LOG2 (covers addresses below BASE_ADDR via wrap).
  - index = offset[DEPTH_LOG2+1:2].
- Response:
  - rsp_valid pulses exactly LATENCY cycles after accept, with rsp_instr = storage[index] and rsp_fault = 0.
  - On any fault, rsp_instr=0 (NOP) and the matching fault bits are set; both bits may be set together.
  - Fully pipelined: one accept per cycle, one response per cycle, in order, no bubbles.
- Read implementation: synchronous storage read provides the first cycle. LATENCY>1 adds LATENCY-1 register stages carrying valid, data and fault.
- Read-after-load: all loads precede RUN, so there is no hazard.
- Reset mid-operation: all in-flight responses are dropped and rsp_valid=0 on the cycle after reset is sampled. A load in progress is abandoned and the pointer returns to 0.
- Elaboration errors: LATENCY outside 1..4, or DEPTH_LOG2 > 28.

Optional Feature:
- IMEM_FETCH_CNT_EN defined:
  - fetch_cnt increments by 1 per accepted fetch, faulting fetches included.
  - Wraps at 2^32; clears on reset.
- Not defined: fetch_cnt is constant 0 and no counter register is built.

Decomposition:
- Package imem_pkg holds:
  - the BASE_ADDR default;
  - the state enum (LOAD, RUN);
  - fault bit indices FAULT_MISALIGN=0, FAULT_RANGE=1;
  - the NOP constant 32'h0000_0000.
- Sub-module imem_resp_pipe: parameterised LATENCY-1 deep delay line for {valid, fault, instr}, with synchronous clear on reset.
- Top level holds the FSM, storage, address check and optional counter.

Test Plan:
- Load words 0x11111111, 0x22222222, 0x33333333 with load_last on the third -> mode=1 next cycle, load_ready=0. Fetch 0x00003004 -> rsp_instr=0x22222222, rsp_fault=0, LATENCY cycles later.
- In RUN, back-to-back fetches of 0x3000, 0x3008, 0x3004 on consecutive cycles -> three consecutive responses in order: 0x11111111, 0x33333333, 0x22222222.
- Fetch 0x00003002 -> rsp_instr=0, rsp_fault=2'b01. Fetch 0x00002FFC -> rsp_fault=2'b10. Fetch 0x00007000 with DEPTH_LOG2=12 -> rsp_fault=2'b10. Fetch 0x00002FFE -> rsp_fault=2'b11.
- req_valid held high during LOAD -> req_ready=0, no rsp_valid. Load 4096 words without load_last -> RUN after the last word; a 4097th load_valid is not accepted.
- Reset asserted with 2 fetches in flight at LATENCY=3 -> no rsp_valid after reset, mode=0, load pointer 0; reload one word and fetch 0x3000 -> returns the new word.
- With IMEM_FETCH_CNT_EN: 5 accepted fetches, including 1 faulting -> fetch_cnt=5; reset -> 0. Without the macro: fetch_cnt stays 0 throughout.
